scr1_imem_sram_bridge: RTL and testbench
========================================

Name: scr1_imem_sram_bridge

Overview:
- Downstream target of the instruction-memory router port (port0 or port1). Converts the core-style imem request/response handshake into accesses to a single-port synchronous SRAM with a fixed, parameterised read latency.
- Supports back-to-back fetches: a new request is accepted in the same cycle the previous response is returned.
- Flags illegal commands, misaligned addresses and out-of-range addresses with an error response.

Parameters:
- SCR1_SRAM_AWIDTH, 14: SRAM word-address width. Region size is 2^SCR1_SRAM_AWIDTH 32-bit words.
- SCR1_READ_LATENCY, 1: cycles from the SRAM enable cycle to valid sram_rdata. Legal range 1..4.
- SCR1_BASE_ADDR, `SCR1_IMEM_AWIDTH'h00010000: byte base address of the region. Aligned to the region size.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_req_ack  out  1  request accepted this cycle
- imem_req  in  1  fetch request
- imem_cmd  in  type_scr1_mem_cmd_e  command; only SCR1_MEM_CMD_RD is legal
- imem_addr  in  `SCR1_IMEM_AWIDTH  byte address
- imem_rdata  out  `SCR1_IMEM_DWIDTH  read data, valid with RDY_OK
- imem_resp  out  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER
- sram_en  out  1  SRAM read enable
- sram_addr  out  SCR1_SRAM_AWIDTH  SRAM word address
- sram_rdata  in  32  SRAM read data, valid SCR1_READ_LATENCY cycles after sram_en

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). On reset:
  - state=IDLE, lat_cnt=0, err_r=0.
  - imem_req_ack=0, imem_resp=SCR1_MEM_RESP_NOTRDY, sram_en=0.
  - sram_addr and imem_rdata are don't-care.
- Request decode, combinational from the current request:
  - err = (imem_cmd!=SCR1_MEM_CMD_RD) | (imem_addr[1:0]!=0) | (imem_addr outside [SCR1_BASE_ADDR, SCR1_BASE_ADDR+4*2^SCR1_SRAM_AWIDTH)).
  - sram_addr = imem_addr[SCR1_SRAM_AWIDTH+1:2].
- FSM states: IDLE, BUSY.
  - resp_fire = (state==BUSY) & (lat_cnt==SCR1_READ_LATENCY).
  - imem_req_ack = (state==IDLE) | resp_fire. It is combinational and independent of imem_req.
  - Accept = imem_req & imem_req_ack.
  - sram_en = accept & ~err. Erroneous requests never touch the SRAM.
- On accept:
  - lat_cnt <= 1, err_r <= err, state <= BUSY.
- In BUSY without resp_fire: lat_cnt increments by 1 per cycle.
- On resp_fire:
  - imem_resp = err_r ? RDY_ER : RDY_OK.
  - imem_rdata = sram_rdata (pass-through, no extra register).
  - If an accept occurs in the same cycle: stay BUSY, lat_cnt <= 1, err_r <= new err.
  - Otherwise: state <= IDLE.
- Outside resp_fire: imem_resp = NOTRDY.
- Latency:
  - Response appears exactly SCR1_READ_LATENCY cycles after the accept cycle, identical for OK and ER.
  - Throughput is one fetch per SCR1_READ_LATENCY cycles. READ_LATENCY=1 gives 1 fetch/cycle.
- At most one outstanding transaction; no buffering; each response is a single-cycle pulse.
- lat_cnt width is 3 bits. It never exceeds SCR1_READ_LATENCY, so no wrap.
- imem_req dropped while BUSY: no effect on the in-flight response.
- Reset asserted mid-transaction: the in-flight response is discarded. After deassertion the first cycle is IDLE with NOTRDY.
- Assertions (synthesis_off):
  - imem_req |-> no X on {imem_cmd, imem_addr}.
  - SCR1_READ_LATENCY within 1..4 (elaboration check).

Test Plan:
1. LAT=1, base 0x00010000: req RD addr 0x00010008 -> ack in cycle 0; sram_en=1 and sram_addr=2 in cycle 0; cycle 1 resp=RDY_OK with rdata=SRAM word 2.
2. LAT=1, req held high for addrs 0x00010000, 0x00010004, 0x00010008 -> ack every cycle; three consecutive RDY_OK carrying words 0, 1, 2.
3. LAT=3, req addr 0x00010010 held high -> ack cycle 0; ack=0 in cycles 1–2; cycle 3 resp=RDY_OK with word 4 and next request acked the same cycle.
4. Errors:
   - addr 0x00010002 -> RDY_ER after LAT cycles, sram_en=0.
   - addr 0x00020000 with AWIDTH=14 (out of range) -> RDY_ER.
   - cmd=SCR1_MEM_CMD_WR -> RDY_ER.
5. LAT=2: error request followed back-to-back by valid RD 0x00010004 -> ER, then OK with word 1; err_r does not leak into the second response.
6. LAT=3: rst_n pulsed low at cycle 1 after accept -> immediately resp=NOTRDY, ack=0, sram_en=0; no response ever emitted for that request; post-reset request serviced normally.

Source files
------------

// File: rtl/scr1_imem_sram_bridge.sv
// scr1_imem_sram_bridge: turns the imem request/response handshake into
// single-port synchronous SRAM reads with a fixed read latency. There is at
// most one fetch in flight. The next request is accepted in the same cycle
// that the previous response is returned.

`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif

`ifndef SCR1_MEMIF_TYPES_DEFINED
`define SCR1_MEMIF_TYPES_DEFINED
typedef enum logic {
  SCR1_MEM_CMD_RD = 1'b0,
  SCR1_MEM_CMD_WR = 1'b1
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
  SCR1_MEM_RESP_NOTRDY = 2'b00,
  SCR1_MEM_RESP_RDY_OK = 2'b01,
  SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;
`endif

module scr1_imem_sram_bridge #(
  parameter int                          SCR1_SRAM_AWIDTH  = 14,
  parameter int                          SCR1_READ_LATENCY = 1,
  parameter logic [`SCR1_IMEM_AWIDTH-1:0] SCR1_BASE_ADDR    = `SCR1_IMEM_AWIDTH'h00010000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req_ack,
  input  logic                          imem_req,
  input  type_scr1_mem_cmd_e            imem_cmd,
  input  logic [`SCR1_IMEM_AWIDTH-1:0]  imem_addr,
  output logic [`SCR1_IMEM_DWIDTH-1:0]  imem_rdata,
  output type_scr1_mem_resp_e           imem_resp,
  output logic                          sram_en,
  output logic [SCR1_SRAM_AWIDTH-1:0]   sram_addr,
  input  logic [31:0]                   sram_rdata
);

  localparam int IAW = `SCR1_IMEM_AWIDTH;

  // One extra bit so the end of a region at the top of the address map
  // does not wrap to zero.
  localparam logic [IAW:0] REGION_BASE = {1'b0, SCR1_BASE_ADDR};
  localparam logic [IAW:0] REGION_END  = REGION_BASE + ((IAW+1)'(1) << (SCR1_SRAM_AWIDTH + 2));
  localparam logic [2:0]   LAT_CNT     = 3'(SCR1_READ_LATENCY);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e     state;
  state_e     state_nxt;
  logic [2:0] lat_cnt;
  logic [2:0] lat_cnt_nxt;
  logic       err_r;
  logic       err_r_nxt;
  logic       req_err_c;
  logic       resp_fire;
  logic       accept;

  // A request is rejected for a non-read command, a misaligned byte address
  // or an address outside the SRAM region.
  function automatic logic req_bad(input type_scr1_mem_cmd_e cmd,
                                   input logic [IAW-1:0]     addr);
    logic [IAW:0] a;
    a = {1'b0, addr};
    return (cmd != SCR1_MEM_CMD_RD) | (addr[1:0] != 2'b00) |
           (a < REGION_BASE) | (a >= REGION_END);
  endfunction

  // Handshake outputs and request decode. The ack is held low while rst_n is
  // asserted so nothing is accepted during an asynchronous reset pulse.
  always_comb begin
    resp_fire    = (state == BUSY) && (lat_cnt == LAT_CNT);
    imem_req_ack = rst_n & ((state == IDLE) | resp_fire);
    accept       = imem_req & imem_req_ack;
    req_err_c    = req_bad(imem_cmd, imem_addr);
    sram_en      = accept & ~req_err_c;
    sram_addr    = imem_addr[SCR1_SRAM_AWIDTH+1:2];
    imem_rdata   = `SCR1_IMEM_DWIDTH'(sram_rdata);
    if (resp_fire) begin
      imem_resp = err_r ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    end else begin
      imem_resp = SCR1_MEM_RESP_NOTRDY;
    end
  end

  // Next-state logic: an accept always (re)starts the latency count, even in
  // the cycle that returns the previous response.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    err_r_nxt   = err_r;
    if (accept) begin
      state_nxt   = BUSY;
      lat_cnt_nxt = 3'd1;
      err_r_nxt   = req_err_c;
    end else if (resp_fire) begin
      state_nxt   = IDLE;
    end else if (state == BUSY) begin
      lat_cnt_nxt = lat_cnt + 3'd1;
    end
  end

  // State register; reset drops any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= 3'd0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      err_r   <= err_r_nxt;
    end
  end

`ifndef SYNTHESIS
  if ((SCR1_READ_LATENCY < 1) || (SCR1_READ_LATENCY > 4)) begin : g_lat_chk
    $error("SCR1_READ_LATENCY must be within 1..4");
  end

  a_req_known : assert property (@(posedge clk) disable iff (!rst_n)
    imem_req |-> !$isunknown({imem_cmd, imem_addr}));
`endif

endmodule

// File: tb/tb_scr1_imem_sram_bridge.sv
// Bench for scr1_imem_sram_bridge: three instances with read latency 1, 2
// and 3 share clock and reset. A table of directed vectors covers the
// handshake corners. A random phase then runs against a cycle-time model.

module tb_scr1_imem_sram_bridge;

  localparam int          NDUT = 3;
  localparam int          AW   = 14;
  localparam logic [31:0] BASE = 32'h0001_0000;

  localparam type_scr1_mem_cmd_e  RD = SCR1_MEM_CMD_RD;
  localparam type_scr1_mem_cmd_e  WR = SCR1_MEM_CMD_WR;
  localparam type_scr1_mem_resp_e NR = SCR1_MEM_RESP_NOTRDY;
  localparam type_scr1_mem_resp_e OK = SCR1_MEM_RESP_RDY_OK;
  localparam type_scr1_mem_resp_e ER = SCR1_MEM_RESP_RDY_ER;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                req   [NDUT];
  type_scr1_mem_cmd_e  cmd   [NDUT];
  logic [31:0]         addr  [NDUT];
  logic                ack   [NDUT];
  logic [31:0]         rdata [NDUT];
  type_scr1_mem_resp_e resp  [NDUT];
  logic                en    [NDUT];
  logic [AW-1:0]       saddr [NDUT];
  logic [31:0]         srd   [NDUT];

  // SRAM model: per-instance delay line of {enable, address}.
  logic                pv [NDUT][4];
  logic [AW-1:0]       pa [NDUT][4];

  int errors = 0;
  int checks = 0;

  // SRAM contents: a fixed scramble of the word index.
  function automatic logic [31:0] word(input logic [31:0] idx);
    return (idx * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    scr1_imem_sram_bridge #(
      .SCR1_SRAM_AWIDTH (AW),
      .SCR1_READ_LATENCY(g + 1),
      .SCR1_BASE_ADDR   (BASE)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req_ack(ack[g]),
      .imem_req    (req[g]),
      .imem_cmd    (cmd[g]),
      .imem_addr   (addr[g]),
      .imem_rdata  (rdata[g]),
      .imem_resp   (resp[g]),
      .sram_en     (en[g]),
      .sram_addr   (saddr[g]),
      .sram_rdata  (srd[g])
    );
    assign srd[g] = (pv[g][g] === 1'b1) ? word(32'(pa[g][g])) : 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 3; k > 0; k--) begin
        pv[d][k] <= pv[d][k-1];
        pa[d][k] <= pa[d][k-1];
      end
      pv[d][0] <= en[d];
      pa[d][0] <= saddr[d];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. It tracks each in-flight fetch by the absolute cycle
  // number at which its response is due.
  function automatic bit bad_req(input type_scr1_mem_cmd_e c, input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (c != RD) || (la % 4 != 0) || (la < longint'(BASE)) ||
           (la >= longint'(BASE) + 4 * (longint'(1) << AW));
  endfunction

  bit          m_busy [NDUT];
  int          m_due  [NDUT];
  bit          m_err  [NDUT];
  logic [31:0] m_addr [NDUT];
  int          cyc = 0;
  bit          m_fire, m_ack, m_acc, m_e;

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!rst_n) begin
        chk($sformatf("rst ack d%0d", d), 32'(ack[d]), 32'd0);
        chk($sformatf("rst en d%0d", d), 32'(en[d]), 32'd0);
        chk($sformatf("rst resp d%0d", d), 32'(resp[d]), 32'(NR));
        m_busy[d] = 1'b0;
      end else begin
        m_fire = m_busy[d] && (cyc == m_due[d]);
        m_ack  = !m_busy[d] || m_fire;
        m_acc  = req[d] && m_ack;
        m_e    = bad_req(cmd[d], addr[d]);
        chk($sformatf("model ack d%0d", d), 32'(ack[d]), 32'(m_ack));
        chk($sformatf("model en d%0d", d), 32'(en[d]), 32'(m_acc && !m_e));
        chk($sformatf("model resp d%0d", d), 32'(resp[d]),
            m_fire ? (m_err[d] ? 32'(ER) : 32'(OK)) : 32'(NR));
        if (m_fire && !m_err[d])
          chk($sformatf("model rdata d%0d", d), rdata[d], word((m_addr[d] - BASE) >> 2));
        if (m_acc && !m_e)
          chk($sformatf("model saddr d%0d", d), 32'(saddr[d]), (addr[d] - BASE) >> 2);
        if (m_acc) begin
          m_busy[d] = 1'b1;
          m_due[d]  = cyc + d + 1;
          m_err[d]  = m_e;
          m_addr[d] = addr[d];
        end else if (m_fire) begin
          m_busy[d] = 1'b0;
        end
      end
    end
    cyc++;
  end

  // Directed vectors: one row per cycle on instance d (latency d+1).
  // sa < 0 skips the sram_addr check; w is the word index returned with RDY_OK.
  typedef struct {
    int                  d;
    bit                  rq;
    type_scr1_mem_cmd_e  c;
    logic [31:0]         a;
    bit                  ak;
    bit                  e;
    int                  sa;
    type_scr1_mem_resp_e r;
    int                  w;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input bit rq, input type_scr1_mem_cmd_e c,
                              input logic [31:0] a, input bit ak, input bit e,
                              input int sa, input type_scr1_mem_resp_e r, input int w);
    vec_t v;
    v.d = d; v.rq = rq; v.c = c; v.a = a; v.ak = ak; v.e = e; v.sa = sa; v.r = r; v.w = w;
    return v;
  endfunction

  task automatic drive_idle();
    for (int d = 0; d < NDUT; d++) req[d] = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk); #1;
    drive_idle();
    req[v.d]  = v.rq;
    cmd[v.d]  = v.c;
    addr[v.d] = v.a;
    @(negedge clk);
    chk($sformatf("vec%0d ack", idx), 32'(ack[v.d]), 32'(v.ak));
    chk($sformatf("vec%0d en", idx), 32'(en[v.d]), 32'(v.e));
    chk($sformatf("vec%0d resp", idx), 32'(resp[v.d]), 32'(v.r));
    if (v.sa >= 0) chk($sformatf("vec%0d saddr", idx), 32'(saddr[v.d]), 32'(v.sa));
    if (v.r == OK) chk($sformatf("vec%0d rdata", idx), rdata[v.d], word(32'(v.w)));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      req[d] = 1'b0; cmd[d] = RD; addr[d] = BASE;
    end

    // Single fetch, LAT=1
    vecs.push_back(mk(0, 1, RD, 32'h0001_0008, 1, 1, 2, NR, 0));
    vecs.push_back(mk(0, 0, RD, 32'h0000_0000, 1, 0, -1, OK, 2));
    // Back-to-back, LAT=1
    vecs.push_back(mk(0, 1, RD, 32'h0001_0000, 1, 1, 0, NR, 0));
    vecs.push_back(mk(0, 1, RD, 32'h0001_0004, 1, 1, 1, OK, 0));
    vecs.push_back(mk(0, 1, RD, 32'h0001_0008, 1, 1, 2, OK, 1));
    vecs.push_back(mk(0, 0, RD, 32'h0000_0000, 1, 0, -1, OK, 2));
    vecs.push_back(mk(0, 0, RD, 32'h0000_0000, 1, 0, -1, NR, 0));
    // LAT=3: held request, accept on the response cycle, req dropped while busy
    vecs.push_back(mk(2, 1, RD, 32'h0001_0010, 1, 1, 4, NR, 0));
    vecs.push_back(mk(2, 1, RD, 32'h0001_0010, 0, 0, -1, NR, 0));
    vecs.push_back(mk(2, 1, RD, 32'h0001_0010, 0, 0, -1, NR, 0));
    vecs.push_back(mk(2, 1, RD, 32'h0001_0014, 1, 1, 5, OK, 4));
    vecs.push_back(mk(2, 0, RD, 32'h0000_0000, 0, 0, -1, NR, 0));
    vecs.push_back(mk(2, 0, RD, 32'h0000_0000, 0, 0, -1, NR, 0));
    vecs.push_back(mk(2, 0, RD, 32'h0000_0000, 1, 0, -1, OK, 5));
    vecs.push_back(mk(2, 0, RD, 32'h0000_0000, 1, 0, -1, NR, 0));
    // Errors and range edges, LAT=1
    vecs.push_back(mk(0, 1, RD, 32'h0001_0002, 1, 0, -1, NR, 0));
    vecs.push_back(mk(0, 1, RD, 32'h0002_0000, 1, 0, -1, ER, 0));
    vecs.push_back(mk(0, 1, WR, 32'h0001_0000, 1, 0, -1, ER, 0));
    vecs.push_back(mk(0, 1, RD, 32'h0000_FFFC, 1, 0, -1, ER, 0));
    vecs.push_back(mk(0, 1, RD, 32'h0001_FFFC, 1, 1, 16383, ER, 0));
    vecs.push_back(mk(0, 0, RD, 32'h0000_0000, 1, 0, -1, OK, 16383));
    vecs.push_back(mk(0, 0, RD, 32'h0000_0000, 1, 0, -1, NR, 0));
    // Error latency matches OK latency, LAT=3
    vecs.push_back(mk(2, 1, RD, 32'h0001_0002, 1, 0, -1, NR, 0));
    vecs.push_back(mk(2, 0, RD, 32'h0000_0000, 0, 0, -1, NR, 0));
    vecs.push_back(mk(2, 0, RD, 32'h0000_0000, 0, 0, -1, NR, 0));
    vecs.push_back(mk(2, 0, RD, 32'h0000_0000, 1, 0, -1, ER, 0));
    // Error then valid back-to-back, LAT=2
    vecs.push_back(mk(1, 1, RD, 32'h0001_0002, 1, 0, -1, NR, 0));
    vecs.push_back(mk(1, 1, RD, 32'h0001_0004, 0, 0, -1, NR, 0));
    vecs.push_back(mk(1, 1, RD, 32'h0001_0004, 1, 1, 1, ER, 0));
    vecs.push_back(mk(1, 0, RD, 32'h0000_0000, 0, 0, -1, NR, 0));
    vecs.push_back(mk(1, 0, RD, 32'h0000_0000, 1, 0, -1, OK, 1));
    vecs.push_back(mk(1, 0, RD, 32'h0000_0000, 1, 0, -1, NR, 0));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset in the middle of a LAT=3 fetch discards its response.
    @(posedge clk); #1;
    drive_idle();
    req[2] = 1'b1; cmd[2] = RD; addr[2] = 32'h0001_0020;
    @(negedge clk);
    chk("rstseq accept ack", 32'(ack[2]), 32'd1);
    chk("rstseq accept en", 32'(en[2]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstseq async ack", 32'(ack[2]), 32'd0);
    chk("rstseq async en", 32'(en[2]), 32'd0);
    chk("rstseq async resp", 32'(resp[2]), 32'(NR));
    @(posedge clk); #1;
    rst_n = 1'b1;
    req[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstseq post resp%0d", k), 32'(resp[2]), 32'(NR));
      chk($sformatf("rstseq post ack%0d", k), 32'(ack[2]), 32'd1);
    end
    apply(mk(2, 1, RD, 32'h0001_000C, 1, 1, 3, NR, 0), 100);
    apply(mk(2, 0, RD, 32'h0000_0000, 0, 0, -1, NR, 0), 101);
    apply(mk(2, 0, RD, 32'h0000_0000, 0, 0, -1, NR, 0), 102);
    apply(mk(2, 0, RD, 32'h0000_0000, 1, 0, -1, OK, 3), 103);

    // Random phase, checked by the model above.
    repeat (3000) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int d = 0; d < NDUT; d++) begin
        req[d] = ($urandom_range(0, 9) < 7);
        cmd[d] = ($urandom_range(0, 15) == 0) ? WR : RD;
        case ($urandom_range(0, 9))
          0:       addr[d] = $urandom;
          1:       addr[d] = BASE + 32'($urandom_range(0, 16383)) * 4 + 32'($urandom_range(1, 3));
          2:       addr[d] = BASE - 4;
          3:       addr[d] = BASE + 4 * 16383;
          4:       addr[d] = BASE + 4 * 16384;
          default: addr[d] = BASE + 32'($urandom_range(0, 16383)) * 4;
        endcase
      end
    end

    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_idle();
    repeat (6) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
